// File: rtl/term_loop_ctrl_pkg.sv
// Shared definitions for the fabric-edge loop-back controller.
// Holds the per-group mode encoding and its 2-bit typedef.
package term_loop_ctrl_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_TIE    = 2'b00,
      MODE_COMB   = 2'b01,
      MODE_REG    = 2'b10,
      MODE_STICKY = 2'b11
   } mode_t;

endpackage

// File: rtl/term_loop_group.sv
// One loop-back wire group: mode decode, state register, output mux.
// Ports: clk, rst, mode, clr (mode change), nend in, sbeg out.
module term_loop_group
   import term_loop_ctrl_pkg::*;
#(
   parameter int GROUP_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  mode_t              mode,
   input  logic               clr,
   input  logic [GROUP_W-1:0] nend,
   output logic [GROUP_W-1:0] sbeg
);

   // q is the REG pipeline stage or the STICKY bits, per mode
   logic [GROUP_W-1:0] q;
   logic [GROUP_W-1:0] q_nxt;

   always_comb begin
      q_nxt = '0;
      case (mode)
         MODE_REG:    q_nxt = nend;
         MODE_STICKY: q_nxt = q | nend;
         MODE_TIE:    q_nxt = '0;
         MODE_COMB:   q_nxt = '0;
         default:     q_nxt = '0;
      endcase
      // a mode change starts the new mode from a clean state
      if (clr) q_nxt = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= q_nxt;
   end

   always_comb begin
      sbeg = '0;
      case (mode)
         MODE_TIE:    sbeg = '0;
         MODE_COMB:   sbeg = nend;
         MODE_REG:    sbeg = q;
         MODE_STICKY: sbeg = q;
         default:     sbeg = '0;
      endcase
   end

endmodule

// File: rtl/term_loop_ctrl.sv
// Fabric-edge loop-back terminator with frame-configured per-group modes.
// Ports: UserCLK/Reset, NEND->SBEG loop bus, FrameData/FrameStrobe config,
// FrameStrobe_O forward, UserCLKo buffered clock, CfgMode readback.
module term_loop_ctrl
   import term_loop_ctrl_pkg::*;
#(
   parameter int NUM_GROUPS      = 5,
   parameter int GROUP_W         = 16,
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int CFG_FRAME       = 0,
   parameter int STROBE_PIPE     = 0
) (
   input  logic                            UserCLK,
   input  logic                            Reset,
   input  logic [NUM_GROUPS*GROUP_W-1:0]   NEND,
   output logic [NUM_GROUPS*GROUP_W-1:0]   SBEG,
   input  logic [FrameBitsPerRow-1:0]      FrameData,
   input  logic [MaxFramesPerCol-1:0]      FrameStrobe,
   output logic [MaxFramesPerCol-1:0]      FrameStrobe_O,
   output logic                            UserCLKo,
   output logic [2*NUM_GROUPS-1:0]         CfgMode
);

   localparam int MW = 2 * NUM_GROUPS;

   if (MW > FrameBitsPerRow) begin : g_bad_width
      $error("mode register wider than FrameData");
   end
   if (CFG_FRAME >= MaxFramesPerCol) begin : g_bad_frame
      $error("CFG_FRAME outside FrameStrobe");
   end

   // clock buffer: straight wire, mapped to a clock buffer cell
   assign UserCLKo = UserCLK;

   logic          strb;
   logic          strb_q;
   logic          armed_q;
   logic          wr;
   logic [MW-1:0] cfg_q;

   assign strb = FrameStrobe[CFG_FRAME];

   // armed_q blocks a strobe that was already high across reset
   // release until it has been seen low once
   assign wr = strb & ~strb_q & armed_q;

   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         strb_q  <= 1'b0;
         armed_q <= 1'b0;
         cfg_q   <= '0;
      end else begin
         strb_q  <= strb;
         armed_q <= armed_q | ~strb;
         if (wr) cfg_q <= FrameData[MW-1:0];
      end
   end

   assign CfgMode = cfg_q;

   // upper FrameData bits are ignored by design
   logic unused_fd;
   assign unused_fd = ^FrameData;

   if (STROBE_PIPE != 0) begin : g_strb_pipe
      logic [MaxFramesPerCol-1:0] fs_q;
      always_ff @(posedge UserCLK or posedge Reset) begin
         if (Reset) fs_q <= '0;
         else       fs_q <= FrameStrobe;
      end
      assign FrameStrobe_O = fs_q;
   end else begin : g_strb_comb
      assign FrameStrobe_O = FrameStrobe;
   end

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      logic clr;
      assign clr = wr & (FrameData[2*g +: 2] != cfg_q[2*g +: 2]);

      term_loop_group #(
         .GROUP_W (GROUP_W)
      ) u_grp (
         .clk  (UserCLK),
         .rst  (Reset),
         .mode (mode_t'(cfg_q[2*g +: 2])),
         .clr  (clr),
         .nend (NEND[g*GROUP_W +: GROUP_W]),
         .sbeg (SBEG[g*GROUP_W +: GROUP_W])
      );
   end

endmodule

// File: tb/tb_term_loop_ctrl.sv
// Randomized self-checking bench for term_loop_ctrl.
// Reference model keeps per-group mode, last sample and sticky bits.
module tb_term_loop_ctrl;

   localparam int NG = 5;
   localparam int GW = 16;
   localparam int W  = NG * GW;
   localparam int MF = 20;
   localparam int FB = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          rst1;
   logic [W-1:0]  nend;
   logic [FB-1:0] fd;
   logic [MF-1:0] fs;

   logic [W-1:0]    sbeg0, sbeg1;
   logic [MF-1:0]   fso0, fso1;
   logic            clko0, clko1;
   logic [2*NG-1:0] cfg0, cfg1;

   always #5 clk = ~clk;

   term_loop_ctrl dut0 (
      .UserCLK       (clk),
      .Reset         (rst),
      .NEND          (nend),
      .SBEG          (sbeg0),
      .FrameData     (fd),
      .FrameStrobe   (fs),
      .FrameStrobe_O (fso0),
      .UserCLKo      (clko0),
      .CfgMode       (cfg0)
   );

   term_loop_ctrl #(.STROBE_PIPE(1)) dut1 (
      .UserCLK       (clk),
      .Reset         (rst1),
      .NEND          (nend),
      .SBEG          (sbeg1),
      .FrameData     (fd),
      .FrameStrobe   (fs),
      .FrameStrobe_O (fso1),
      .UserCLKo      (clko1),
      .CfgMode       (cfg1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model state
   logic [1:0]    m_mode   [NG];
   logic [GW-1:0] m_last   [NG];
   logic [GW-1:0] m_sticky [NG];
   bit            m_prev;
   bit            m_seen_low;
   logic [MF-1:0] exp_fso1;

   task automatic model_reset();
      for (int g = 0; g < NG; g++) begin
         m_mode[g]   = 2'b00;
         m_last[g]   = '0;
         m_sticky[g] = '0;
      end
      m_prev     = 1'b0;
      m_seen_low = 1'b0;
   endtask

   function automatic logic [W-1:0] model_sbeg();
      logic [W-1:0] r;
      r = '0;
      for (int g = 0; g < NG; g++) begin
         case (m_mode[g])
            2'b01:   r[g*GW +: GW] = nend[g*GW +: GW];
            2'b10:   r[g*GW +: GW] = m_last[g];
            2'b11:   r[g*GW +: GW] = m_sticky[g];
            default: r[g*GW +: GW] = '0;
         endcase
      end
      return r;
   endfunction

   function automatic logic [2*NG-1:0] model_cfg();
      logic [2*NG-1:0] r;
      for (int g = 0; g < NG; g++) r[2*g +: 2] = m_mode[g];
      return r;
   endfunction

   // called exactly at a rising edge, with pre-edge inputs
   task automatic model_edge();
      bit            s, w;
      logic [1:0]    nm;
      logic [GW-1:0] ng;
      s = fs[0];
      w = s && !m_prev && m_seen_low;
      if (!s) m_seen_low = 1'b1;
      m_prev = s;
      for (int g = 0; g < NG; g++) begin
         nm = w ? fd[2*g +: 2] : m_mode[g];
         ng = nend[g*GW +: GW];
         if (nm != m_mode[g]) begin
            m_last[g]   = '0;
            m_sticky[g] = '0;
         end else begin
            m_last[g]   = ng;
            m_sticky[g] = m_sticky[g] | ng;
         end
         m_mode[g] = nm;
      end
      exp_fso1 = rst1 ? '0 : fs;
   endtask

   task automatic check_outputs();
      chk("sbeg",   sbeg0, model_sbeg());
      chk("cfg",    cfg0,  model_cfg());
      chk("fso_c",  fso0,  fs);
      chk("fso_p",  fso1,  exp_fso1);
      chk("clko",   clko0, clk);
   endtask

   // enters and leaves just after a rising edge
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      rst1 = 1'b1;
      model_reset();
      exp_fso1 = '0;
      #1;
      chk("rst_sbeg", sbeg0, '0);
      chk("rst_cfg",  cfg0,  '0);
      chk("rst_fsop", fso1,  '0);
      @(negedge clk);
      check_outputs();
      rst  = 1'b0;
      rst1 = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wr_mode(input logic [2*NG-1:0] v);
      fd = $urandom;
      fd[2*NG-1:0] = v;
      fs[0] = 1'b1;
      cycle();
      fs[0] = 1'b0;
      fd = $urandom;
      cycle();
   endtask

   logic [FB-1:0] first_fd;

   initial begin
      rst  = 1'b1;
      rst1 = 1'b1;
      nend = '1;
      fd   = '0;
      fs   = '0;
      do_reset();
      cycle();
      chk("idle_sbeg", sbeg0, '0);
      chk("idle_cfg",  cfg0,  '0);

      // all groups combinational
      wr_mode(10'h155);
      chk("comb_cfg", cfg0, 10'h155);
      nend[31:0]  = $urandom;
      nend[63:32] = $urandom;
      nend[79:64] = 16'($urandom);
      #1;
      chk("comb_sbeg", sbeg0, nend);
      cycle();

      // all groups registered
      wr_mode(10'h2AA);
      nend = '0;
      cycle();
      nend[15:0] = 16'hA5A5;
      #1;
      chk("reg_before", sbeg0[15:0], 16'h0);
      cycle();
      nend = '0;
      chk("reg_after", sbeg0[15:0], 16'hA5A5);
      cycle();

      // all groups sticky
      wr_mode(10'h3FF);
      nend = 80'h8;
      cycle();
      nend = '0;
      chk("sticky_set", sbeg0[3], 1'b1);
      cycle();
      cycle();
      chk("sticky_hold", sbeg0[3], 1'b1);
      wr_mode(10'h3FF);
      chk("sticky_same", sbeg0[3], 1'b1);
      wr_mode(10'h3FD);
      chk("sticky_comb", sbeg0[3], 1'b0);
      wr_mode(10'h3FF);
      chk("sticky_clr", sbeg0[3], 1'b0);

      // long strobe: one write with first-cycle data
      fs[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         fd = $urandom;
         if (i == 0) first_fd = fd;
         cycle();
      end
      fs[0] = 1'b0;
      cycle();
      chk("long_strb", cfg0, first_fd[2*NG-1:0]);

      // strobe high across reset release
      fs[0] = 1'b1;
      fd = 32'h155;
      do_reset();
      for (int i = 0; i < 3; i++) cycle();
      chk("rst_strb_hi", cfg0, 10'h0);
      fs[0] = 1'b0;
      cycle();
      fs[0] = 1'b1;
      cycle();
      fs[0] = 1'b0;
      cycle();
      chk("rst_strb_rearm", cfg0, 10'h155);

      // strobe pipeline and mid-pulse reset
      fs = 20'h80001;
      cycle();
      chk("fsop_dly", fso1, 20'h80001);
      rst1 = 1'b1;
      #1;
      chk("fsop_rst", fso1, 20'h0);
      exp_fso1 = '0;
      #1;
      rst1 = 1'b0;
      fs = '0;
      cycle();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         nend[31:0]  = $urandom;
         nend[63:32] = $urandom;
         nend[79:64] = 16'($urandom);
         fd = $urandom;
         fs = 20'($urandom);
         fs[0] = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) do_reset();
         else cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
